// File: rtl/rs_sched_pkg.sv
// rs_sched_pkg: shared sizes and state encoding for the reservation-station issue arbiter
package rs_sched_pkg;
    localparam int NUM_REQ = 16;
    localparam int IDX_W = 4;
    typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/orGate16.sv
// orGate16: 16-input OR reduction
module orGate16 (
    input  logic [15:0] a,
    output logic        y
);
    assign y = |a;
endmodule

// File: rtl/rr_pick16.sv
// rr_pick16: round-robin pick of the first set request at or above ptr, wrapping 15 to 0
module rr_pick16 import rs_sched_pkg::*; (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);
    logic [NUM_REQ-1:0] rot;
    logic [IDX_W-1:0]   off;
    always_comb begin
        rot = NUM_REQ'({req, req} >> ptr);
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) if (rot[i]) off = IDX_W'(i);
        found = |req;
        idx = ptr + off;
    end
endmodule

// File: rtl/rs_issue_arbiter.sv
// rs_issue_arbiter: round-robin issue arbiter with valid/ready handshake to a functional unit
module rs_issue_arbiter import rs_sched_pkg::*; (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               flush,
    input  logic               fu_ready,
    output logic               any_req,
    output logic               issue_valid,
    output logic [IDX_W-1:0]   issue_idx,
    output logic [NUM_REQ-1:0] grant,
    output logic [15:0]        issue_cnt
);
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d, idx_q, idx_d, sel_ptr, pick_idx;
    logic [NUM_REQ-1:0] grant_q, grant_d, sel_req;
    logic [15:0]        cnt_q, cnt_d;
    logic               acc, load, found;

    orGate16 u_or (.a(req), .y(any_req));
    rr_pick16 u_pick (.req(sel_req), .ptr(sel_ptr), .found(found), .idx(pick_idx));

    // the accepted requester still shows req this cycle, so it is masked from the next pick
    always_comb begin
        acc = state_q == GRANT && fu_ready && !flush;
        load = (state_q == IDLE || acc) && !flush;
        sel_ptr = acc ? idx_q + 4'd1 : ptr_q;
        sel_req = acc ? req & ~grant_q : req;
        ptr_d = sel_ptr;
        cnt_d = cnt_q + {15'd0, acc};
        state_d = flush ? IDLE : load ? (found ? GRANT : IDLE) : state_q;
        idx_d = load && found ? pick_idx : idx_q;
        grant_d = state_d == GRANT ? NUM_REQ'(1) << idx_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q <= '0;
            idx_q <= '0;
            grant_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            idx_q <= idx_d;
            grant_q <= grant_d;
            cnt_q <= cnt_d;
        end
    end

    assign issue_valid = state_q == GRANT;
    assign issue_idx = idx_q;
    assign grant = grant_q;
    assign issue_cnt = cnt_q;
endmodule

// File: tb/tb_rs_issue_arbiter.sv
// tb_rs_issue_arbiter: randomized and directed checks against a behavioural arbiter model
module tb_rs_issue_arbiter;
    logic        clk = 0, reset_n = 0, flush = 0, fu_ready = 0;
    logic [15:0] req = '0;
    logic        any_req, issue_valid;
    logic [3:0]  issue_idx;
    logic [15:0] grant, issue_cnt;
    int          checks = 0, failures = 0;
    bit          drop = 0, checking = 0;
    bit          m_valid = 0, m_acc = 0;
    int          m_idx = 0, m_ptr = 0, m_acc_idx = 0;
    int unsigned m_cnt = 0;

    rs_issue_arbiter dut (
        .clk(clk), .reset_n(reset_n), .req(req), .flush(flush), .fu_ready(fu_ready),
        .any_req(any_req), .issue_valid(issue_valid), .issue_idx(issue_idx),
        .grant(grant), .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin : model
        logic [15:0] r;
        r = req;
        m_acc = 0;
        if (!reset_n) begin
            m_valid = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
        end else if (flush) begin
            m_valid = 0;
        end else begin
            if (m_valid && fu_ready) begin
                m_acc = 1;
                m_acc_idx = m_idx;
                m_cnt = (m_cnt + 1) % 65536;
                m_ptr = (m_idx + 1) % 16;
                r[m_idx] = 0;
            end
            if (!m_valid || m_acc) begin
                m_valid = 0;
                for (int k = 0; k < 16; k++)
                    if (!m_valid && r[(m_ptr + k) % 16]) begin
                        m_valid = 1;
                        m_idx = (m_ptr + k) % 16;
                    end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (checking) begin
        chk("any_req", 32'(any_req), 32'(|req));
        chk("issue_valid", 32'(issue_valid), 32'(m_valid));
        chk("grant", 32'(grant), m_valid ? 32'd1 << m_idx : 32'd0);
        if (m_valid) chk("issue_idx", 32'(issue_idx), 32'(m_idx));
        chk("issue_cnt", 32'(issue_cnt), m_cnt);
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (drop && m_acc) req[m_acc_idx] = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        step();
        reset_n = 1;
    endtask

    initial begin
        do_reset();
        checking = 1;
        chk("rst_valid", 32'(issue_valid), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_cnt", 32'(issue_cnt), 0);
        chk("rst_idx", 32'(issue_idx), 0);
        req = 16'h0010;
        step();
        chk("t1_valid", 32'(issue_valid), 1);
        chk("t1_idx", 32'(issue_idx), 4);
        step();
        do_reset();
        chk("t1_rst_valid", 32'(issue_valid), 0);
        chk("t1_rst_grant", 32'(grant), 0);
        chk("t1_rst_cnt", 32'(issue_cnt), 0);
        step();
        chk("t1_regrant", 32'(issue_idx), 4);

        do_reset();
        req = 16'hFFFF;
        fu_ready = 1;
        for (int k = 1; k <= 17; k++) begin
            step();
            chk("rr_idx", 32'(issue_idx), 32'((k - 1) % 16));
            chk("rr_valid", 32'(issue_valid), 1);
        end
        chk("rr_cnt", 32'(issue_cnt), 16);

        fu_ready = 0;
        do_reset();
        req = 16'h0101;
        step();
        repeat (5) begin
            chk("bp_idx", 32'(issue_idx), 0);
            chk("bp_grant", 32'(grant), 32'h0001);
            step();
        end
        fu_ready = 1;
        step();
        chk("bp_next", 32'(issue_idx), 8);
        chk("bp_cnt", 32'(issue_cnt), 1);

        do_reset();
        drop = 1;
        req = 16'h2000;
        step();
        chk("wr_13", 32'(issue_idx), 13);
        step();
        chk("wr_idle", 32'(issue_valid), 0);
        req = 16'h8003;
        step();
        chk("wr_15", 32'(issue_idx), 15);
        step();
        chk("wr_0", 32'(issue_idx), 0);
        step();
        chk("wr_1", 32'(issue_idx), 1);
        step();
        chk("wr_end", 32'(issue_valid), 0);
        chk("wr_cnt", 32'(issue_cnt), 4);

        do_reset();
        req = 16'h0020;
        step();
        step();
        req = 16'h0040;
        step();
        chk("fl_idx", 32'(issue_idx), 6);
        flush = 1;
        step();
        chk("fl_valid", 32'(issue_valid), 0);
        chk("fl_grant", 32'(grant), 0);
        chk("fl_cnt", 32'(issue_cnt), 1);
        flush = 0;
        fu_ready = 0;
        req = 16'h0041;
        step();
        chk("fl_ptr", 32'(issue_idx), 6);

        drop = 0;
        do_reset();
        req = 16'hFFFF;
        fu_ready = 1;
        repeat (65537) step();
        chk("cw_cnt", 32'(issue_cnt), 0);
        chk("cw_valid", 32'(issue_valid), 1);

        drop = 1;
        do_reset();
        req = '0;
        repeat (3000) begin
            req = req | 16'($urandom & $urandom & $urandom);
            fu_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 31) == 0;
            reset_n = $urandom_range(0, 199) != 0;
            step();
        end
        reset_n = 1;
        flush = 0;
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
